// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
//   Prefetch FIFO between instruction fetch and instruction decode. Holds up to
//   DEPTH {pc, instruction} pairs so fetch can keep running while decode is
//   stalled. A taken branch (flush) discards every buffered wrong-path entry in
//   one cycle.
//
// Optional feature (macro IF_ID_BUF_BYPASS_EN):
//   When defined, an input beat arriving while the buffer is empty and decode is
//   ready is forwarded combinationally to out_* (zero-cycle latency) and is not
//   written into the array. When undefined there is no input-to-output
//   combinational path and the minimum latency is one cycle.
//
// Ports:
//   clk             system clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   flush           branch taken, empties the buffer this cycle
//   in_valid        fetch presents a beat
//   in_ready        buffer can accept a beat (fetch freeze = ~in_ready)
//   in_pc           pc of the fetched beat
//   in_instruction  fetched instruction word
//   out_valid       head entry valid for decode
//   out_ready       decode consumes the head this cycle
//   out_pc          pc of the head entry (0 when empty)
//   out_instruction instruction word of the head entry (0 when empty)
//   count           current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module if_id_buffer #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_pc,
    input  logic [WORD_WIDTH-1:0] in_instruction,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_pc,
    output logic [WORD_WIDTH-1:0] out_instruction,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 2 * WORD_WIDTH;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    logic full_s;
    logic empty_s;
    logic bypass_s;
    logic push_s;
    logic pop_s;

    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});

    // Bypass qualifier: empty buffer, decode free, beat present, no flush
    always_comb begin
        bypass_s = 1'b0;
`ifdef IF_ID_BUF_BYPASS_EN
        if (!rst && !flush && in_valid && out_ready && empty_s) begin
            bypass_s = 1'b1;
        end else begin
            bypass_s = 1'b0;
        end
`endif
    end

    // Handshake decode; a bypassed beat is neither written nor popped
    always_comb begin
        in_ready  = ~rst & ~full_s;
        out_valid = (~rst & ~flush & ~empty_s) | bypass_s;
        push_s    = in_valid & in_ready & ~flush & ~bypass_s;
        pop_s     = ~rst & ~flush & ~empty_s & out_ready;
    end

    // Head data: forwarded input on bypass, stored head when non-empty, else zero
    always_comb begin
        out_pc          = {WORD_WIDTH{1'b0}};
        out_instruction = {WORD_WIDTH{1'b0}};
        if (bypass_s) begin
            out_pc          = in_pc;
            out_instruction = in_instruction;
        end else if (!empty_s) begin
            out_pc          = mem_q[rd_ptr_q][ENTRY_W-1:WORD_WIDTH];
            out_instruction = mem_q[rd_ptr_q][WORD_WIDTH-1:0];
        end else begin
            out_pc          = {WORD_WIDTH{1'b0}};
            out_instruction = {WORD_WIDTH{1'b0}};
        end
    end

    // Next-state for pointers, count and array; flush wins over push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = {in_pc, in_instruction};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [2:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard of {pc, instruction} expected at the head, plus model occupancy
    logic [63:0] sb[$];
    int          m_count = 0;

    if_id_buffer #(.WORD_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instruction(in_instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instruction(out_instruction),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_5A5A;
    endfunction

    // Drive one beat's inputs (called right after a negedge)
    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid       = v;
        in_pc          = pc;
        in_instruction = instr_of(pc);
        out_ready      = rdy;
        flush          = fl;
        #2;
    endtask

    // Advance one clock; update the reference model from the driven inputs
    task automatic tick();
        logic acc, pp, byp;
        byp = 1'b0;
`ifdef IF_ID_BUF_BYPASS_EN
        byp = !rst && !flush && in_valid && out_ready && (m_count == 0);
`endif
        acc = !rst && !flush && in_valid && (m_count != 4) && !byp;
        pp  = !rst && !flush && (m_count != 0) && out_ready;
        @(posedge clk);
        if (rst || flush) begin
            sb.delete();
            m_count = 0;
        end else begin
            if (pp) void'(sb.pop_front());
            if (acc) sb.push_back({in_pc, in_instruction});
            m_count = m_count + int'(acc) - int'(pp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL idle_count: got %0d want 0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_instruction !== 32'h0) begin n_fail++; $display("FAIL idle_out_instr: got %h want 0", out_instruction); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h10, 1'b0, 1'b0);
            n_cmp++; if (int'(count) !== m_count || m_count != 4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
            n_cmp++; if (out_pc !== sb[0][63:32]) begin n_fail++; $display("FAIL full_head_pc: got %h want %h", out_pc, sb[0][63:32]); end
            tick();
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (out_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h want %h", i, out_pc, 32'(i * 4)); end
            n_cmp++; if ({out_pc, out_instruction} !== sb[0]) begin n_fail++; $display("FAIL drain_entry[%0d]: got %h want %h", i, {out_pc, out_instruction}, sb[0]); end
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL drained_count: got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL drained_pc: got %h want 0", out_pc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] next_pc;
        logic [31:0] want_pc;
        next_pc = 32'h200;
        want_pc = 32'h200;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, next_pc, 1'b0, 1'b0);
            tick();
            next_pc += 32'h4;
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, next_pc, 1'b1, 1'b0);
            n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 2", i, count); end
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== want_pc) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %b/%h want 1/%h", i, out_valid, out_pc, want_pc); end
            n_cmp++; if ({out_pc, out_instruction} !== sb[0]) begin n_fail++; $display("FAIL b2b_entry[%0d]: got %h want %h", i, {out_pc, out_instruction}, sb[0]); end
            tick();
            next_pc += 32'h4;
            want_pc += 32'h4;
        end
    endtask

    task automatic test_flush();
        // Top up from 2 to 3 entries
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h20, 1'b1, 1'b1);
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL preflush_count: got %0d want 3", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        tick();
        // Second consecutive flush cycle keeps the buffer empty
        drive(1'b1, 32'h24, 1'b1, 1'b1);
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
        tick();
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hold: got %0d/%b want 0/0", count, out_valid); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin n_fail++; $display("FAIL post_flush_head: got %b/%h want 1/00000040", out_valid, out_pc); end
        n_cmp++; if (count !== 3'd1 || sb.size() != 1) begin n_fail++; $display("FAIL post_flush_count: got %0d want 1", count); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_latency();
        drive(1'b1, 32'h100, 1'b1, 1'b0);
`ifdef IF_ID_BUF_BYPASS_EN
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_fail++; $display("FAIL bypass_same_cycle: got %b/%h want 1/00000100", out_valid, out_pc); end
        n_cmp++; if (out_instruction !== instr_of(32'h100)) begin n_fail++; $display("FAIL bypass_instr: got %h want %h", out_instruction, instr_of(32'h100)); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_after: got %0d/%b want 0/0", count, out_valid); end
`else
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nobypass_same_cycle: got %b want 0", out_valid); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_fail++; $display("FAIL nobypass_next: got %b/%h want 1/00000100", out_valid, out_pc); end
        n_cmp++; if ({out_pc, out_instruction} !== sb[0]) begin n_fail++; $display("FAIL nobypass_entry: got %h want %h", {out_pc, out_instruction}, sb[0]); end
        tick();
`endif
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'(32'h500 + i * 4), 1'b0, 1'b0);
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 32'h600, 1'b1, 1'b0);
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_mask: got %b/%b want 0/0", in_ready, out_valid); end
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_empty: got %0d/%b want 0/0", count, out_valid); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 32'h0; in_instruction = 32'h0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_latency();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
